// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared state encoding for the fetch buffer controller
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQ       = 2'b01,
        WAIT_FREE = 2'b11,
        REDIR     = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_ptr_ctr.sv
// rtl/fetch_ptr_ctr.sv - wrap-around slot pointer with clear and increment
module fetch_ptr_ctr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;

    // Slot count is a power of two, so natural overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (clr_i) begin
            ptr_q <= '0;
        end else if (inc_i) begin
            ptr_q <= ptr_q + W'(1);
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_buf_ctrl.sv
// rtl/fetch_buf_ctrl.sv - circular fetch buffer controller between I-cache and decode
module fetch_buf_ctrl
    import cpu_fetch_pkg::*;
#(
    parameter  int NUM_ENTRIES = 2,
    localparam int PTR_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_en,
    input  logic                   flush,
    input  logic                   ic_ack,
    input  logic                   de_consume,
    output logic                   ic_req,
    output logic [NUM_ENTRIES-1:0] ld_buf,
    output logic [NUM_ENTRIES-1:0] valid_vec,
    output logic [PTR_W-1:0]       rd_ptr,
    output logic [PTR_W-1:0]       wr_ptr,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    fetch_state_e           state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic                   fill, take;

    assign full   = (count_q == CNT_W'(NUM_ENTRIES));
    assign empty  = (count_q == '0);
    assign ic_req = (state_q == REQ);
    assign fill   = ic_req & ic_ack & ~flush;
    assign take   = de_consume & ~empty & ~flush;
    assign ld_buf = fill ? (NUM_ENTRIES'(1) << wr_ptr) : '0;

    fetch_ptr_ctr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (take),
        .ptr_o (rd_ptr)
    );

    fetch_ptr_ctr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (fill),
        .ptr_o (wr_ptr)
    );

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (fill) valid_d[wr_ptr] = 1'b1;
            if (take) valid_d[rd_ptr] = 1'b0;
            case ({fill, take})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = REDIR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en) state_d = full ? WAIT_FREE : REQ;
                end
                REQ: begin
                    // A fill into the last free slot parks us so ic_req never sees full.
                    if (!fetch_en && !fill)
                        state_d = IDLE;
                    else if (fill && !take && count_q == CNT_W'(NUM_ENTRIES - 1))
                        state_d = WAIT_FREE;
                end
                WAIT_FREE: begin
                    if (take) state_d = fetch_en ? REQ : IDLE;
                end
                REDIR: begin
                    state_d = fetch_en ? REQ : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign valid_vec = valid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_buf_ctrl.sv
// tb/tb_fetch_buf_ctrl.sv - self-checking bench for fetch_buf_ctrl (2- and 4-slot instances)
module tb_fetch_buf_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_WAIT  = 2;
    localparam int M_REDIR = 3;

    logic clk;
    logic rst_n;
    logic fe [2];
    logic fl [2];
    logic ack[2];
    logic con[2];

    logic [1:0] ld0, vv0;
    logic [0:0] rd0, wr0;
    logic [1:0] cnt0;
    logic [3:0] ld1, vv1;
    logic [1:0] rd1, wr1;
    logic [2:0] cnt1;
    logic       req0, full0, emp0, req1, full1, emp1;

    int n_vec = 0;
    int n_err = 0;

    int nent  [2] = '{2, 4};
    int m_st  [2];
    int m_cnt [2];
    int m_rd  [2];
    int m_wr  [2];
    int m_fills[2];
    int m_takes[2];

    fetch_buf_ctrl #(.NUM_ENTRIES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fe[0]), .flush(fl[0]), .ic_ack(ack[0]),
        .de_consume(con[0]), .ic_req(req0), .ld_buf(ld0), .valid_vec(vv0),
        .rd_ptr(rd0), .wr_ptr(wr0), .count(cnt0), .full(full0), .empty(emp0)
    );

    fetch_buf_ctrl #(.NUM_ENTRIES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fe[1]), .flush(fl[1]), .ic_ack(ack[1]),
        .de_consume(con[1]), .ic_req(req1), .ld_buf(ld1), .valid_vec(vv1),
        .rd_ptr(rd1), .wr_ptr(wr1), .count(cnt1), .full(full1), .empty(emp1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int obs_of(input int d, input int which);
        case (which)
            0: return d == 0 ? int'(req0)  : int'(req1);
            1: return d == 0 ? int'(ld0)   : int'(ld1);
            2: return d == 0 ? int'(vv0)   : int'(vv1);
            3: return d == 0 ? int'(rd0)   : int'(rd1);
            4: return d == 0 ? int'(wr0)   : int'(wr1);
            5: return d == 0 ? int'(cnt0)  : int'(cnt1);
            6: return d == 0 ? int'(full0) : int'(full1);
            default: return d == 0 ? int'(emp0) : int'(emp1);
        endcase
    endfunction

    function automatic string tg(input int d, input string s);
        return $sformatf("n%0d_%s", nent[d], s);
    endfunction

    // A slot is occupied when it lies within count slots from the head.
    function automatic int model_valid(input int d);
        int v = 0;
        for (int s = 0; s < nent[d]; s++)
            if (((s - m_rd[d] + nent[d]) % nent[d]) < m_cnt[d]) v |= (1 << s);
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = M_IDLE; m_cnt[d] = 0; m_rd[d] = 0; m_wr[d] = 0;
            m_fills[d] = 0; m_takes[d] = 0;
        end
    endtask

    task automatic check_reset(input int d);
        check(tg(d, "rst_ic_req"), obs_of(d, 0), 0);
        check(tg(d, "rst_ld_buf"), obs_of(d, 1), 0);
        check(tg(d, "rst_valid"),  obs_of(d, 2), 0);
        check(tg(d, "rst_rd_ptr"), obs_of(d, 3), 0);
        check(tg(d, "rst_wr_ptr"), obs_of(d, 4), 0);
        check(tg(d, "rst_count"),  obs_of(d, 5), 0);
        check(tg(d, "rst_full"),   obs_of(d, 6), 0);
        check(tg(d, "rst_empty"),  obs_of(d, 7), 1);
    endtask

    task automatic drv(input int d, input logic f_en, input logic f_fl,
                       input logic f_ack, input logic f_con);
        fe[d] = f_en; fl[d] = f_fl; ack[d] = f_ack; con[d] = f_con;
    endtask

    // Called just after a falling edge: checks pre-edge outputs, clocks once, advances the model.
    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            int n = nent[d];
            bit req  = (m_st[d] == M_REQ);
            bit fill = req && ack[d] && !fl[d];
            check(tg(d, "ic_req"), obs_of(d, 0), int'(req));
            check(tg(d, "ld_buf"), obs_of(d, 1), fill ? (1 << m_wr[d]) : 0);
            check(tg(d, "valid"),  obs_of(d, 2), model_valid(d));
            check(tg(d, "rd_ptr"), obs_of(d, 3), m_rd[d]);
            check(tg(d, "wr_ptr"), obs_of(d, 4), m_wr[d]);
            check(tg(d, "count"),  obs_of(d, 5), m_cnt[d]);
            check(tg(d, "full"),   obs_of(d, 6), int'(m_cnt[d] == n));
            check(tg(d, "empty"),  obs_of(d, 7), int'(m_cnt[d] == 0));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int  n = nent[d];
            int  pre = m_cnt[d];
            bit  fill = (m_st[d] == M_REQ) && ack[d] && !fl[d];
            bit  take = con[d] && pre > 0 && !fl[d];
            if (fl[d]) begin
                m_st[d] = M_REDIR; m_cnt[d] = 0; m_rd[d] = 0; m_wr[d] = 0;
            end else begin
                if (fill) begin m_wr[d] = (m_wr[d] + 1) % n; m_fills[d]++; end
                if (take) begin m_rd[d] = (m_rd[d] + 1) % n; m_takes[d]++; end
                m_cnt[d] = pre + int'(fill) - int'(take);
                case (m_st[d])
                    M_IDLE:  if (fe[d]) m_st[d] = (pre == n) ? M_WAIT : M_REQ;
                    M_REQ:   if (!fe[d] && !fill) m_st[d] = M_IDLE;
                             else if (fill && !take && pre == n - 1) m_st[d] = M_WAIT;
                    M_WAIT:  if (take) m_st[d] = fe[d] ? M_REQ : M_IDLE;
                    default: m_st[d] = fe[d] ? M_REQ : M_IDLE;
                endcase
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        #1;
        check_reset(0);
        check_reset(1);
        do_reset();

        // 2-slot: fill to full, consume, wrap, simultaneous fill+take
        drv(0, 1, 0, 0, 0); tick();
        drv(0, 1, 0, 1, 0); tick();
        drv(0, 1, 0, 1, 0); tick();
        check("t1_full",   int'(full0), 1);
        check("t1_ic_req", int'(req0),  0);
        check("t1_count",  int'(cnt0),  2);
        drv(0, 1, 0, 1, 0); tick();
        drv(0, 1, 0, 0, 1); tick();
        check("t2_rd_ptr", int'(rd0),  1);
        check("t2_ic_req", int'(req0), 1);
        drv(0, 1, 0, 1, 0); tick();
        drv(0, 1, 0, 0, 1); tick();
        drv(0, 1, 0, 1, 1); tick();
        check("t3_count", int'(cnt0), 1);

        // flush with a same-cycle ack, then the one-cycle redirect bubble
        drv(0, 1, 1, 1, 1); tick();
        check("t4_empty", int'(emp0), 1);
        drv(0, 1, 0, 0, 0); tick();
        drv(0, 1, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 1); tick();
        drv(0, 0, 0, 1, 0); tick();
        check("t5_count", int'(cnt0), 0);

        // 4-slot: 9 fills interleaved with 7 consumes
        do_reset();
        for (int i = 0; i < 100 && !(m_fills[1] == 9 && m_takes[1] == 7); i++) begin
            drv(1, 1, 0, m_fills[1] < 9, m_takes[1] < 7 && m_cnt[1] > 0 && (i % 3 != 0));
            tick();
        end
        check("t6_fills", m_fills[1], 9);
        check("t6_takes", m_takes[1], 7);
        check("t6_count", int'(cnt1), 2);
        check("t6_rd_ptr", int'(rd1), 3);
        check("t6_wr_ptr", int'(wr1), 1);
        for (int i = 0; i < 5 && m_st[1] != M_REQ; i++) begin
            drv(1, 1, 0, 0, 0);
            tick();
        end
        check("t6_in_req", int'(req1), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset(1);
        check_reset(0);
        @(negedge clk);
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();

        // randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++)
                drv(d, $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
